mem_port_arbiter_rv32: RTL
==========================

Name: mem_port_arbiter_rv32

Overview:
- Shares the single external memory port between instruction fetch (IF requester) and the execute/mem-stage load-store path (DM requester).
- Sits between the fetch unit, the execute-stage memory outputs (read/write flag, address, data) and the memory bus.
- Runs one transaction at a time: registered req/ack handshake, fixed data priority, bounded starvation guard for fetch.

Parameters:
- MAX_DM_BURST, 4: max consecutive DM grants while an IF request is pending; the next arbitration must then go to IF.
- TIMEOUT_CYCLES, 255: memory-ack wait limit. Used only with ARB_TIMEOUT_EN.

Ports:
- iCLK  in  1  clock.
- iRST  in  1  reset, synchronous, active-high.
- iIF_REQ  in  1  fetch request; held until oIF_ACK.
- iIF_ADDR  in  32  fetch address (always a read, all byte lanes).
- oIF_ACK  out  1  one-cycle completion pulse.
- oIF_RDATA  out  32  fetched word; valid while oIF_ACK=1.
- iDM_REQ  in  1  data request; held until oDM_ACK.
- iDM_RW  in  1  1 = read, 0 = write.
- iDM_ADDR  in  32  data address.
- iDM_WDATA  in  32  write data.
- iDM_BE  in  4  byte enables.
- oDM_ACK  out  1  one-cycle completion pulse.
- oDM_RDATA  out  32  load data; valid while oDM_ACK=1.
- oMEM_REQ  out  1  bus request.
- oMEM_RW  out  1  bus direction; 1 = read.
- oMEM_ADDR  out  32  bus address.
- oMEM_WDATA  out  32  bus write data.
- oMEM_BE  out  4  bus byte enables.
- iMEM_ACK  in  1  bus completion; iMEM_RDATA valid in the same cycle.
- iMEM_RDATA  in  32  bus read data.
- oBUSY  out  1  high in any state other than IDLE.
- oERR  out  1  timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset: all outputs registered.
  - oMEM_REQ, oIF_ACK, oDM_ACK, oBUSY, oERR = 0.
  - oMEM_ADDR, oMEM_WDATA, oIF_RDATA, oDM_RDATA = 0; oMEM_BE = 0; oMEM_RW = 1.
  - FSM = IDLE; burst counter = 0.
  - Reset mid-transaction aborts immediately; no ack is issued.
- FSM states: IDLE, XFER_IF, XFER_DM, DONE.
- IDLE arbitration:
  - iDM_REQ=1 and (iIF_REQ=0 or burst counter < MAX_DM_BURST) -> XFER_DM.
  - Else iIF_REQ=1 -> XFER_IF.
  - Else stay in IDLE.
  - On that same edge, latch the winner's RW/ADDR/WDATA/BE into the oMEM_* registers and set oMEM_REQ=1. Fetch uses RW=1, BE=4'hF, WDATA=0.
- Burst counter:
  - Increments on each DM grant made while iIF_REQ=1.
  - Clears on any IF grant, and on any DM grant made while iIF_REQ=0.
  - Saturates at MAX_DM_BURST.
- XFER_x:
  - oMEM_* held stable while iMEM_ACK=0.
  - On iMEM_ACK=1: oMEM_REQ<=0, owner's RDATA<=iMEM_RDATA (reads only; DM writes leave oDM_RDATA unchanged), owner's ACK<=1, go to DONE.
- DONE:
  - Lasts exactly 1 cycle with the ACK visible; no arbitration this cycle.
  - ACK<=0 on exit, then -> IDLE.
  - A requester deasserts REQ the cycle after it sees its ACK, so no duplicate grant is possible.
- Latency:
  - Request sampled in IDLE at edge N; oMEM_REQ high from cycle N+1.
  - Zero-wait memory (ACK in first XFER cycle): ack visible at N+2.
  - Minimum 3 cycles per transaction, including the IDLE arbitration cycle.
- Simultaneous IF and DM requests with counter < MAX_DM_BURST: DM wins.
- iMEM_ACK is ignored in IDLE and DONE.
- RDATA registers hold their last value between acks.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to XFER_x and increments every XFER cycle with iMEM_ACK=0.
  - When it reaches TIMEOUT_CYCLES: oMEM_REQ<=0, owner's ACK<=1, owner's RDATA<=0, oERR<=1 for the DONE cycle, then IDLE.
  - iMEM_ACK on the same edge as the timeout takes precedence: normal completion, oERR=0.
- Undefined: the arbiter waits indefinitely in XFER_x; oERR is constant 0; no wait counter exists.

Test Plan:
- IF-only read: iIF_REQ=1, addr 0x100, memory acks in first XFER cycle with 0xDEADBEEF -> oMEM_REQ high cycle 1; oIF_ACK=1 and oIF_RDATA=0xDEADBEEF in cycle 2.
- Simultaneous requests: IF 0x200 and DM write 0x8000/0x12345678/BE=4'h3 -> DM bus transaction first (RW=0, BE=3); IF granted in the IDLE after DM's DONE.
- Starvation: iIF_REQ and iDM_REQ held continuously (DM re-requests after each ack), MAX_DM_BURST=4 -> grant order DM,DM,DM,DM,IF,DM,...
- Wait states: memory delays iMEM_ACK 5 cycles on a DM read -> oMEM_ADDR/RW/BE stable all 5 cycles; single oDM_ACK pulse; no IF grant during the transfer.
- Reset mid-XFER_DM: iRST for 1 cycle -> next cycle oMEM_REQ=0, oDM_ACK=0, oBUSY=0; a following request is arbitrated normally.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never acks IF read -> after 8 wait cycles oIF_ACK=1, oIF_RDATA=0, oERR=1 for 1 cycle; FSM returns to IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_rv32.sv
// Arbiter sharing one external memory port between instruction fetch and load/store.
// Optional ack-wait timeout is compiled in with `define ARB_TIMEOUT_EN.
module mem_port_arbiter_rv32 #(
    parameter int unsigned MAX_DM_BURST   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iIF_REQ,
    input  logic [31:0] iIF_ADDR,
    output logic        oIF_ACK,
    output logic [31:0] oIF_RDATA,
    input  logic        iDM_REQ,
    input  logic        iDM_RW,
    input  logic [31:0] iDM_ADDR,
    input  logic [31:0] iDM_WDATA,
    input  logic [3:0]  iDM_BE,
    output logic        oDM_ACK,
    output logic [31:0] oDM_RDATA,
    output logic        oMEM_REQ,
    output logic        oMEM_RW,
    output logic [31:0] oMEM_ADDR,
    output logic [31:0] oMEM_WDATA,
    output logic [3:0]  oMEM_BE,
    input  logic        iMEM_ACK,
    input  logic [31:0] iMEM_RDATA,
    output logic        oBUSY,
    output logic        oERR
);

    localparam int unsigned BURST_W = $clog2(MAX_DM_BURST + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER_IF = 2'd1,
        XFER_DM = 2'd2,
        DONE    = 2'd3
    } stateT;

    stateT state;
    stateT stateNext;

    logic               memReq,   memReqNxt;
    logic               memRw,    memRwNxt;
    logic [31:0]        memAddr,  memAddrNxt;
    logic [31:0]        memWdata, memWdataNxt;
    logic [3:0]         memBe,    memBeNxt;
    logic               ifAck,    ifAckNxt;
    logic [31:0]        ifRdata,  ifRdataNxt;
    logic               dmAck,    dmAckNxt;
    logic [31:0]        dmRdata,  dmRdataNxt;
    logic               busy,     busyNxt;
    logic               err,      errNxt;
    logic [BURST_W-1:0] burstCnt, burstCntNxt;

    logic dmGrant;
    logic ifGrant;
    logic timeoutHit;

    // DM has priority unless fetch has already waited out a full DM burst
    assign dmGrant = (state == IDLE) && iDM_REQ &&
                     (!iIF_REQ || (burstCnt < BURST_W'(MAX_DM_BURST)));
    assign ifGrant = (state == IDLE) && !dmGrant && iIF_REQ;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] waitCnt;

    // Fires on the wait cycle that would bring the counter to TIMEOUT_CYCLES
    assign timeoutHit = ((state == XFER_IF) || (state == XFER_DM)) && !iMEM_ACK &&
                        (waitCnt == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            waitCnt <= '0;
        end else if (((state == XFER_IF) || (state == XFER_DM)) && !iMEM_ACK) begin
            waitCnt <= waitCnt + WAIT_W'(1);
        end else begin
            waitCnt <= '0;
        end
    end
`else
    localparam int unsigned unusedTimeoutCycles = TIMEOUT_CYCLES;

    assign timeoutHit = 1'b0;
`endif

    // State register
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (dmGrant) begin
                    stateNext = XFER_DM;
                end else if (ifGrant) begin
                    stateNext = XFER_IF;
                end
            end
            XFER_IF, XFER_DM: begin
                if (iMEM_ACK || timeoutHit) begin
                    stateNext = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Next values of the registered outputs and burst counter
    always_comb begin
        memReqNxt   = memReq;
        memRwNxt    = memRw;
        memAddrNxt  = memAddr;
        memWdataNxt = memWdata;
        memBeNxt    = memBe;
        ifAckNxt    = ifAck;
        ifRdataNxt  = ifRdata;
        dmAckNxt    = dmAck;
        dmRdataNxt  = dmRdata;
        errNxt      = err;
        burstCntNxt = burstCnt;
        busyNxt     = (stateNext != IDLE);

        case (state)
            IDLE: begin
                if (dmGrant) begin
                    memReqNxt   = 1'b1;
                    memRwNxt    = iDM_RW;
                    memAddrNxt  = iDM_ADDR;
                    memWdataNxt = iDM_WDATA;
                    memBeNxt    = iDM_BE;
                    if (!iIF_REQ) begin
                        burstCntNxt = '0;
                    end else if (burstCnt != BURST_W'(MAX_DM_BURST)) begin
                        burstCntNxt = burstCnt + BURST_W'(1);
                    end
                end else if (ifGrant) begin
                    memReqNxt   = 1'b1;
                    memRwNxt    = 1'b1;
                    memAddrNxt  = iIF_ADDR;
                    memWdataNxt = 32'h0;
                    memBeNxt    = 4'hF;
                    burstCntNxt = '0;
                end
            end
            XFER_IF: begin
                if (iMEM_ACK) begin
                    memReqNxt  = 1'b0;
                    ifAckNxt   = 1'b1;
                    ifRdataNxt = iMEM_RDATA;
                end else if (timeoutHit) begin
                    memReqNxt  = 1'b0;
                    ifAckNxt   = 1'b1;
                    ifRdataNxt = 32'h0;
                    errNxt     = 1'b1;
                end
            end
            XFER_DM: begin
                if (iMEM_ACK) begin
                    memReqNxt = 1'b0;
                    dmAckNxt  = 1'b1;
                    if (memRw) begin
                        dmRdataNxt = iMEM_RDATA;
                    end
                end else if (timeoutHit) begin
                    memReqNxt  = 1'b0;
                    dmAckNxt   = 1'b1;
                    dmRdataNxt = 32'h0;
                    errNxt     = 1'b1;
                end
            end
            DONE: begin
                ifAckNxt = 1'b0;
                dmAckNxt = 1'b0;
                errNxt   = 1'b0;
            end
            default: begin
                memReqNxt = 1'b0;
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            memReq   <= 1'b0;
            memRw    <= 1'b1;
            memAddr  <= 32'h0;
            memWdata <= 32'h0;
            memBe    <= 4'h0;
            ifAck    <= 1'b0;
            ifRdata  <= 32'h0;
            dmAck    <= 1'b0;
            dmRdata  <= 32'h0;
            busy     <= 1'b0;
            err      <= 1'b0;
            burstCnt <= '0;
        end else begin
            memReq   <= memReqNxt;
            memRw    <= memRwNxt;
            memAddr  <= memAddrNxt;
            memWdata <= memWdataNxt;
            memBe    <= memBeNxt;
            ifAck    <= ifAckNxt;
            ifRdata  <= ifRdataNxt;
            dmAck    <= dmAckNxt;
            dmRdata  <= dmRdataNxt;
            busy     <= busyNxt;
            err      <= errNxt;
            burstCnt <= burstCntNxt;
        end
    end

    assign oMEM_REQ   = memReq;
    assign oMEM_RW    = memRw;
    assign oMEM_ADDR  = memAddr;
    assign oMEM_WDATA = memWdata;
    assign oMEM_BE    = memBe;
    assign oIF_ACK    = ifAck;
    assign oIF_RDATA  = ifRdata;
    assign oDM_ACK    = dmAck;
    assign oDM_RDATA  = dmRdata;
    assign oBUSY      = busy;
    assign oERR       = err;

endmodule
